pipe_sum_accum: RTL and testbench
=================================

Name: pipe_sum_accum

Overview:
- Downstream consumer of the 4-input pipelined carry-save adder (Y = a+b+c+d, 6-bit operands, 8-bit result, 4-cycle latency).
- Tracks which adder results are real using a valid delay line matched to the adder latency.
- Accumulates CNT consecutive valid results into one block and presents block sum and mean through a valid/ready output register.
- The adder cannot stall, so a block that completes while the output is still held is dropped and flagged.

Parameters:
- LAT, 4: adder latency in cycles, from operands presented to Y valid.
- IN_W, 8: width of Y.
- LOG2_CNT, 2: log2 of results per block.
- CNT, 1<<LOG2_CNT: results per block.
- ACC_W, IN_W+LOG2_CNT: accumulator width, 10 by default; cannot overflow.

Ports:
- clk  in  1  rising-edge clock shared with the adder.
- rst  in  1  asynchronous, active-high reset.
- src_valid  in  1  high in the cycle a/b/c/d are driven into the adder.
- y  in  IN_W  adder output Y.
- out_valid  out  1  block result available.
- out_ready  in  1  consumer accepts the result.
- acc_sum  out  ACC_W  sum of CNT results.
- acc_mean  out  IN_W  acc_sum >> LOG2_CNT (truncating).
- ovf  out  1  sticky: a completed block was dropped.
- blk_max  out  IN_W  largest Y in the block (ACC_MAX_EN only).

Behaviour:
- Reset (async, immediate): valid pipe, cnt, acc, out_valid, acc_sum, acc_mean, ovf and blk_max all 0.
- Valid pipe: LAT-bit shift register; src_valid shifts in every cycle. y_valid = vp[LAT-1].
  - src_valid at cycle t gives y_valid at cycle t+LAT, aligned with the matching Y.
  - Adder reset-flush garbage never registers as valid.
- Accumulate: on y_valid, acc <= (cnt==0 ? y : acc + y) and cnt <= cnt+1, wrapping at CNT.
  - Cycles without y_valid hold acc and cnt (bubbles allowed).
- Block done (y_valid && cnt==CNT-1): final = acc + y, zero-extended to ACC_W.
  - Slot free (!out_valid, or out_valid && out_ready in the same cycle): load acc_sum=final and acc_mean=final[ACC_W-1:LOG2_CNT]; out_valid=1 next cycle.
  - Slot busy (out_valid && !out_ready): block discarded, held output unchanged, ovf <= 1.
  - cnt returns to 0 in both cases.
- Output FSM:
  - OUT_EMPTY → OUT_FULL on load.
  - OUT_FULL → OUT_EMPTY on out_ready with no simultaneous load.
  - OUT_FULL → OUT_FULL on accept and load in the same cycle; the new data replaces the old and out_valid stays 1.
- acc_sum and acc_mean are stable while out_valid && !out_ready.
- ovf clears only on rst.
- Latency: last src_valid of a block at cycle t → out_valid high at t+LAT+1.
- Reset mid-block: the partial block is lost; the first valid after reset starts a fresh block.

Optional Feature:
- Macro ACC_MAX_EN.
- Defined: a running max register, reset on the first valid result of each block (cnt==0) and updated with max(run, y). blk_max loads alongside acc_sum using the block-final max.
- Undefined: no max logic; blk_max is tied to 0.

Decomposition:
- Package pipe_sum_pkg holds ADD_LAT=4, Y_W=8 and the OUT_EMPTY/OUT_FULL state enum.
- Sub-module valid_delay (parameter LAT, async active-high reset, 1-bit shift line) is used for the valid pipe.

Test Plan:
- a=b=c=d=10 for 4 consecutive src_valid cycles, out_ready=1 → out_valid one cycle after the last y_valid; acc_sum=160, acc_mean=40, ovf=0.
- All operands 63 for 4 valid cycles → acc_sum=1008, acc_mean=252, no wrap; with ACC_MAX_EN, blk_max=252.
- Y sequence 4,8,12,20 with 2-cycle src_valid bubbles between samples → acc_sum=44, acc_mean=11; bubbles ignored.
- out_ready=0, 8 valid results of value 40 → first block held (acc_sum=160); second dropped, ovf=1. Then out_ready=1 → out_valid falls; ovf stays 1.
- 2 valid results, then rst pulse mid-stream, then 4 results of 40 → single block acc_sum=160. No valid is seen for garbage Y during the LAT cycles after reset.
- Block completes in the same cycle as out_ready on a full slot → new data loaded, out_valid held high continuously, ovf=0.

Source files
------------

// File: rtl/pipe_sum_pkg.sv
// pipe_sum_pkg: constants and types shared by the pipe_sum_accum block.
//   ADD_LAT     - latency of the upstream 4-input carry-save adder (cycles)
//   Y_W         - width of the adder result Y
//   out_state_t - occupancy of the single-entry output register
package pipe_sum_pkg;

  localparam int ADD_LAT = 4;
  localparam int Y_W     = 8;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/valid_delay.sv
// valid_delay: LAT-deep 1-bit shift line that moves a valid flag along the
// adder's pipeline so it arrives in the same cycle as the matching result.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; clears every stage
//   din  - valid flag entering the line
//   dout - valid flag delayed by LAT cycles
module valid_delay #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] vp;

  generate
    if (LAT == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vp <= '0;
        else     vp <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vp <= '0;
        else     vp <= {vp[LAT-2:0], din};
      end
    end
  endgenerate

  assign dout = vp[LAT-1];

endmodule

// File: rtl/pipe_sum_accum.sv
// pipe_sum_accum: consumer of the pipelined 4-input adder. It aligns a valid
// flag with the adder result, sums CNT consecutive valid results into a block
// and offers the block sum and mean through a single-entry valid/ready
// register. The adder cannot be stalled, so a block that finishes while the
// output is still held is thrown away and the sticky ovf flag is raised.
// Optional feature macro: ACC_MAX_EN (adds the per-block maximum on blk_max;
// without it blk_max is tied to 0).
// Ports:
//   clk       - rising-edge clock shared with the adder
//   rst       - asynchronous active-high reset
//   src_valid - operands are being driven into the adder this cycle
//   y         - adder output Y
//   out_valid - block result available
//   out_ready - consumer accepts the result
//   acc_sum   - sum of the CNT results of the block
//   acc_mean  - acc_sum >> LOG2_CNT, truncated
//   ovf       - sticky: a completed block was dropped
//   blk_max   - largest Y in the block
module pipe_sum_accum
  import pipe_sum_pkg::*;
#(
  parameter int LAT      = ADD_LAT,
  parameter int IN_W     = Y_W,
  parameter int LOG2_CNT = 2,
  parameter int CNT      = 1 << LOG2_CNT,
  parameter int ACC_W    = IN_W + LOG2_CNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  input  logic [IN_W-1:0]  y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_sum,
  output logic [IN_W-1:0]  acc_mean,
  output logic             ovf,
  output logic [IN_W-1:0]  blk_max
);

  localparam logic [LOG2_CNT-1:0] CNT_LAST = LOG2_CNT'(CNT - 1);

  function automatic logic [IN_W-1:0] mean_of(input logic [ACC_W-1:0] v);
    return IN_W'(v >> LOG2_CNT);
  endfunction

  function automatic logic [IN_W-1:0] max_of(input logic [IN_W-1:0] p,
                                             input logic [IN_W-1:0] q);
    return (p > q) ? p : q;
  endfunction

  logic                y_valid;
  logic [LOG2_CNT-1:0] cnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    blk_final;
  logic                blk_done;
  logic                slot_free;
  logic                load;
  out_state_t          state;

  // ---- stage: valid flag travels alongside the adder pipeline ----
  valid_delay #(.LAT(LAT)) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (src_valid),
    .dout (y_valid)
  );

  // ---- stage: block accumulation ----
  // The first result of a block overwrites acc, so no separate clear is needed.
  assign blk_final = (cnt == '0) ? ACC_W'(y) : acc + ACC_W'(y);
  assign blk_done  = y_valid && (cnt == CNT_LAST);
  assign slot_free = (state == OUT_EMPTY) || out_ready;
  assign load      = blk_done && slot_free;

  // cnt wraps to 0 by itself because CNT is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (y_valid) begin
      cnt <= cnt + 1'b1;
      acc <= blk_final;
    end
  end

  // ---- stage: output register and occupancy ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OUT_EMPTY;
      acc_sum  <= '0;
      acc_mean <= '0;
      ovf      <= 1'b0;
    end else begin
      if (load) begin
        state    <= OUT_FULL;
        acc_sum  <= blk_final;
        acc_mean <= mean_of(blk_final);
      end else if ((state == OUT_FULL) && out_ready) begin
        state <= OUT_EMPTY;
      end
      if (blk_done && !slot_free) ovf <= 1'b1;
    end
  end

  assign out_valid = (state == OUT_FULL);

`ifdef ACC_MAX_EN
  logic [IN_W-1:0] run_max;
  logic [IN_W-1:0] max_final;

  assign max_final = (cnt == '0) ? y : max_of(run_max, y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max <= '0;
      blk_max <= '0;
    end else begin
      if (y_valid) run_max <= max_final;
      if (load)    blk_max <= max_final;
    end
  end
`else
  assign blk_max = '0;
`endif

endmodule

// File: tb/tb_pipe_sum_accum.sv
module tb_pipe_sum_accum;

  logic       clk;
  logic       rst;
  logic       src_valid;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] acc_sum;
  logic [7:0] acc_mean;
  logic       ovf;
  logic [7:0] blk_max;

  logic [5:0] a, b, c, d;
  logic [7:0] ypipe [4];

  int n_tests = 0;
  int n_fail  = 0;

  pipe_sum_accum dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_sum   (acc_sum),
    .acc_mean  (acc_mean),
    .ovf       (ovf),
    .blk_max   (blk_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the 4-cycle adder: not reset, so it flushes stale data.
  always @(posedge clk) begin
    ypipe[0] <= 8'(a) + 8'(b) + 8'(c) + 8'(d);
    for (int i = 1; i < 4; i++) ypipe[i] <= ypipe[i-1];
  end
  assign y = ypipe[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [5:0] ia, ib, ic, id);
    src_valid = v;
    a = ia; b = ib; c = ic; d = id;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
  endtask

  initial begin
    rst = 1'b1; src_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0; d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_acc_sum",   32'(acc_sum),   0);
    chk("rst_acc_mean",  32'(acc_mean),  0);
    chk("rst_ovf",       32'(ovf),       0);
    chk("rst_blk_max",   32'(blk_max),   0);
    rst = 1'b0;
    repeat (5) idle();

    // Block of four 40s, out_valid exactly LAT+1 after the last src_valid
    repeat (4) cyc(1'b1, 6'd10, 6'd10, 6'd10, 6'd10);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t1_early_out_valid", 32'(out_valid), 0);
    end
    idle();
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_acc_sum",   32'(acc_sum),   160);
    chk("t1_acc_mean",  32'(acc_mean),  40);
    chk("t1_ovf",       32'(ovf),       0);
    idle();
    chk("t1_accept_out_valid", 32'(out_valid), 0);

    // Maximum operands, no wrap
    repeat (4) cyc(1'b1, 6'd63, 6'd63, 6'd63, 6'd63);
    repeat (4) idle();
    chk("t2_out_valid", 32'(out_valid), 1);
    chk("t2_acc_sum",   32'(acc_sum),   1008);
    chk("t2_acc_mean",  32'(acc_mean),  252);
`ifdef ACC_MAX_EN
    chk("t2_blk_max",   32'(blk_max),   252);
`else
    chk("t2_blk_max",   32'(blk_max),   0);
`endif
    idle();

    // Y = 4, 8, 12, 20 with two-cycle bubbles
    cyc(1'b1, 6'd1, 6'd1, 6'd1, 6'd1); idle(); idle();
    cyc(1'b1, 6'd2, 6'd2, 6'd2, 6'd2); idle(); idle();
    cyc(1'b1, 6'd3, 6'd3, 6'd3, 6'd3); idle(); idle();
    cyc(1'b1, 6'd5, 6'd5, 6'd5, 6'd5);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t3_early_out_valid", 32'(out_valid), 0);
    end
    idle();
    chk("t3_out_valid", 32'(out_valid), 1);
    chk("t3_acc_sum",   32'(acc_sum),   44);
    chk("t3_acc_mean",  32'(acc_mean),  11);
`ifdef ACC_MAX_EN
    chk("t3_blk_max",   32'(blk_max),   20);
`endif
    idle();
    repeat (3) idle();

    // Held output, second block (all 20s) dropped
    out_ready = 1'b0;
    repeat (4) cyc(1'b1, 6'd10, 6'd10, 6'd10, 6'd10);
    repeat (4) cyc(1'b1, 6'd5, 6'd5, 6'd5, 6'd5);
    chk("t4_first_out_valid", 32'(out_valid), 1);
    chk("t4_first_acc_sum",   32'(acc_sum),   160);
    chk("t4_first_ovf",       32'(ovf),       0);
    repeat (4) idle();
    chk("t4_held_out_valid", 32'(out_valid), 1);
    chk("t4_held_acc_sum",   32'(acc_sum),   160);
    chk("t4_held_acc_mean",  32'(acc_mean),  40);
    chk("t4_ovf",            32'(ovf),       1);
    out_ready = 1'b1;
    idle();
    chk("t4_drain_out_valid", 32'(out_valid), 0);
    chk("t4_ovf_sticky",      32'(ovf),       1);
    idle();
    chk("t4_ovf_sticky2",     32'(ovf),       1);
    rst = 1'b1;
    #1;
    chk("t4_async_rst_ovf", 32'(ovf), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) idle();

    // Reset mid-block: two 60s accumulated, two more in flight
    repeat (4) cyc(1'b1, 6'd15, 6'd15, 6'd15, 6'd15);
    idle(); idle();
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 0);
    cyc(1'b0, 6'd63, 6'd63, 6'd63, 6'd63);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 6'd63, 6'd63, 6'd63, 6'd63);
      chk("t5_garbage_out_valid", 32'(out_valid), 0);
    end
    repeat (4) cyc(1'b1, 6'd10, 6'd10, 6'd10, 6'd10);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t5_early_out_valid", 32'(out_valid), 0);
    end
    idle();
    chk("t5_out_valid", 32'(out_valid), 1);
    chk("t5_acc_sum",   32'(acc_sum),   160);
    chk("t5_ovf",       32'(ovf),       0);
    idle();
    chk("t5_accept_out_valid", 32'(out_valid), 0);
    repeat (3) idle();

    // Accept and load in the same cycle
    out_ready = 1'b0;
    repeat (4) cyc(1'b1, 6'd10, 6'd10, 6'd10, 6'd10);
    repeat (4) cyc(1'b1, 6'd5, 6'd5, 6'd5, 6'd5);
    chk("t6_first_out_valid", 32'(out_valid), 1);
    chk("t6_first_acc_sum",   32'(acc_sum),   160);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t6_hold_out_valid", 32'(out_valid), 1);
      chk("t6_hold_acc_sum",   32'(acc_sum),   160);
    end
    out_ready = 1'b1;
    idle();
    chk("t6_swap_out_valid", 32'(out_valid), 1);
    chk("t6_swap_acc_sum",   32'(acc_sum),   80);
    chk("t6_swap_acc_mean",  32'(acc_mean),  20);
    chk("t6_ovf",            32'(ovf),       0);
`ifdef ACC_MAX_EN
    chk("t6_blk_max",        32'(blk_max),   20);
`endif
    idle();
    chk("t6_drain_out_valid", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
